// File: rtl/segre_mem_responder_if.sv
// Arbiter <-> line-memory request/response bundle; master = cache arbiter, slave = responder.
// cache_id encoding: 0 = ICACHE, 1 = DCACHE.
interface segre_mem_responder_if;
  typedef struct packed {
    logic         cache_id;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] cache_line;
  } cache_mem_req_t;

  logic           req_valid_i;
  logic           req_ready_o;
  cache_mem_req_t req_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic           rsp_cache_id_o;
  logic           rsp_wr_o;
  logic [31:0]    rsp_addr_o;
  logic [127:0]   rsp_data_o;

  modport slave (
    input  req_valid_i, req_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_cache_id_o, rsp_wr_o, rsp_addr_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_cache_id_o, rsp_wr_o, rsp_addr_o, rsp_data_o
  );
endinterface

// File: rtl/segre_mem_responder.sv
// Fixed-latency line memory behind a request FIFO; response LATENCY+1 cycles after accept, held until rsp_ready.
// SEGRE_MEM_STATS_EN adds rd_cnt_o/wr_cnt_o completed-response counters.
module segre_mem_responder #(
  parameter int MEM_LINES      = 1024,
  parameter int LATENCY        = 4,
  parameter int REQ_FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  segre_mem_responder_if.slave bus,
  output logic                 err_o
`ifdef SEGRE_MEM_STATS_EN
  ,
  output logic [31:0]          rd_cnt_o,
  output logic [31:0]          wr_cnt_o
`endif
);
  localparam int LINE_W = 128;
  localparam int M      = $clog2(LINE_W / 8);
  localparam int IW     = $clog2(MEM_LINES);
  localparam int AW     = $clog2(REQ_FIFO_DEPTH);
  localparam int PW     = AW + 1;
  localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic              err_q;
  logic              fifo_id_q   [REQ_FIFO_DEPTH];
  logic              fifo_wr_q   [REQ_FIFO_DEPTH];
  logic [31:0]       fifo_addr_q [REQ_FIFO_DEPTH];
  logic [LINE_W-1:0] fifo_line_q [REQ_FIFO_DEPTH];
  logic [LINE_W-1:0] mem_q       [MEM_LINES];
  logic              cur_id_q;
  logic              cur_wr_q;
  logic [31:0]       cur_addr_q;
  logic [LINE_W-1:0] cur_line_q;
  logic [LINE_W-1:0] rsp_data_q;
  logic              rsp_valid_q;

  logic          full;
  logic          empty;
  logic          legal;
  logic          push;
  logic          pop;
  logic          svc_done;
  logic [AW-1:0] head;
  logic [IW-1:0] idx;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign legal    = bus.req_i.rd ^ bus.req_i.wr;
  assign push     = bus.req_valid_i && !full && legal;
  assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_RESP) && bus.rsp_ready_i));
  assign svc_done = (state_q == S_BUSY) && (cnt_q == '0);
  assign head     = rd_ptr_q[AW-1:0];
  assign idx      = cur_addr_q[M +: IW];

  // Queue storage and the line store carry no reset; writes survive rst_i.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id_q[wr_ptr_q[AW-1:0]]   <= bus.req_i.cache_id;
      fifo_wr_q[wr_ptr_q[AW-1:0]]   <= bus.req_i.wr;
      fifo_addr_q[wr_ptr_q[AW-1:0]] <= {bus.req_i.addr[31:M], {M{1'b0}}};
      fifo_line_q[wr_ptr_q[AW-1:0]] <= bus.req_i.cache_line;
    end
    if (svc_done && cur_wr_q) begin
      mem_q[idx] <= cur_line_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (bus.req_valid_i && !full && !legal) err_q <= 1'b1;
    end
  end

  // A pop always starts a new service, whether from IDLE or straight out of a completed RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_id_q    <= 1'b0;
      cur_wr_q    <= 1'b0;
      cur_addr_q  <= '0;
      cur_line_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else if (pop) begin
      cur_id_q    <= fifo_id_q[head];
      cur_wr_q    <= fifo_wr_q[head];
      cur_addr_q  <= fifo_addr_q[head];
      cur_line_q  <= fifo_line_q[head];
      cnt_q       <= CW'(LATENCY - 1);
      state_q     <= S_BUSY;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_BUSY: begin
          if (svc_done) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cur_wr_q ? cur_line_q : mem_q[idx];
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SEGRE_MEM_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (rsp_valid_q && bus.rsp_ready_i) begin
      if (cur_wr_q) wr_cnt_q <= wr_cnt_q + 32'd1;
      else          rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

  assign bus.req_ready_o    = !full;
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_cache_id_o = cur_id_q;
  assign bus.rsp_wr_o       = cur_wr_q;
  assign bus.rsp_addr_o     = cur_addr_q;
  assign bus.rsp_data_o     = rsp_data_q;
  assign err_o              = err_q;
endmodule

// File: tb/tb_segre_mem_responder.sv
// Directed and randomized bench for segre_mem_responder against an in-order transaction model.
module tb_segre_mem_responder;
  localparam int LATENCY = 4;
  localparam logic [127:0] LINE_A = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic clk = 1'b0;
  logic rst;
  logic err;
`ifdef SEGRE_MEM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  segre_mem_responder_if bus();

  segre_mem_responder #(
    .MEM_LINES(1024), .LATENCY(LATENCY), .REQ_FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .err_o(err)
`ifdef SEGRE_MEM_STATS_EN
    ,
    .rd_cnt_o(rd_cnt),
    .wr_cnt_o(wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         held;
  logic [127:0] mem_m[int];
  logic         exp_err;
  bit           rand_rdy = 0;
  bit           hold_vld = 0;
  int checks = 0, errors = 0, n_acc = 0, n_rsp = 0, rd_done = 0, wr_done = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Responses are strictly in order, so the line value seen by a read is fixed at accept time.
  task automatic model_accept();
    int   idx;
    exp_t e;
    if (bus.req_i.rd == bus.req_i.wr) begin
      exp_err = 1'b1;
    end else begin
      idx    = int'((bus.req_i.addr >> 4) & 32'h3FF);
      e.id   = bus.req_i.cache_id;
      e.wr   = bus.req_i.wr;
      e.addr = bus.req_i.addr & 32'hFFFF_FFF0;
      if (bus.req_i.wr) begin
        mem_m[idx] = bus.req_i.cache_line;
        e.data     = bus.req_i.cache_line;
      end else begin
        e.data = mem_m[idx];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    if (rand_rdy) bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
    if (hold_vld) begin
      check("rsp_held_valid", bus.rsp_valid_o, 1'b1);
      check("rsp_held_data", bus.rsp_data_o, held.data);
      check("rsp_held_addr", bus.rsp_addr_o, held.addr);
    end
    hold_vld  = bus.rsp_valid_o && !bus.rsp_ready_i;
    held.data = bus.rsp_data_o;
    held.addr = bus.rsp_addr_o;
    if (bus.rsp_valid_o && bus.rsp_ready_i) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("spurious_rsp", bus.rsp_valid_o, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_cache_id", bus.rsp_cache_id_o, e.id);
        check("rsp_wr", bus.rsp_wr_o, e.wr);
        check("rsp_addr", bus.rsp_addr_o, e.addr);
        check("rsp_data", bus.rsp_data_o, e.data);
        if (e.wr) wr_done++;
        else      rd_done++;
      end
    end
    if (bus.req_valid_i && bus.req_ready_o) begin
      n_acc++;
      model_accept();
    end
    @(posedge clk);
    #1;
    check("err_o", err, exp_err);
  endtask

  task automatic set_req(input logic id, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [127:0] line);
    bus.req_i.cache_id   = id;
    bus.req_i.rd         = rd;
    bus.req_i.wr         = wr;
    bus.req_i.addr       = addr;
    bus.req_i.cache_line = line;
  endtask

  task automatic send(input logic id, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [127:0] line);
    int   n = 0;
    logic ok;
    set_req(id, rd, wr, addr, line);
    bus.req_valid_i = 1'b1;
    do begin
      ok = bus.req_ready_o;
      step();
      n++;
    end while (!ok && n < 200);
    check("send_accept", ok, 1'b1);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid_o) && n < 500) begin
      step();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, bus.rsp_valid_o, 1'b0);
    check({tag, "_req_ready"}, bus.req_ready_o, 1'b1);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_rsp_addr"}, bus.rsp_addr_o, 32'h0);
    check({tag, "_rsp_data"}, bus.rsp_data_o, 128'h0);
    check({tag, "_rsp_wr"}, bus.rsp_wr_o, 1'b0);
    check({tag, "_rsp_id"}, bus.rsp_cache_id_o, 1'b0);
  endtask

  initial begin
    int n;
    int a0;
    int base;
    logic [31:0] raddr;
    logic [127:0] snap;

    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_i       = '0;
    bus.rsp_ready_i = 1'b0;
    exp_err         = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    for (int i = 0; i < 20; i++) begin
      check("idle_rsp_valid", bus.rsp_valid_o, 1'b0);
      check("idle_req_ready", bus.req_ready_o, 1'b1);
      step();
    end

    // Write ack then aliased-offset read of the same line, with latency measurement
    bus.rsp_ready_i = 1'b1;
    send(1'b1, 1'b0, 1'b1, 32'h40, LINE_A);
    n = 0;
    while (!bus.rsp_valid_o && n < 50) begin step(); n++; end
    check("wack_valid", bus.rsp_valid_o, 1'b1);
    check("wack_wr", bus.rsp_wr_o, 1'b1);
    check("wack_id", bus.rsp_cache_id_o, 1'b1);
    check("wack_addr", bus.rsp_addr_o, 32'h40);
    drain();
    repeat (2) step();
    set_req(1'b0, 1'b1, 1'b0, 32'h4C, '0);
    bus.req_valid_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin step(); n++; end
    check("rd_latency", n, LATENCY + 1);
    check("rd_data", bus.rsp_data_o, LINE_A);
    check("rd_id", bus.rsp_cache_id_o, 1'b0);
    check("rd_wr", bus.rsp_wr_o, 1'b0);
    check("rd_addr", bus.rsp_addr_o, 32'h40);
    drain();

    // Burst of 6 reads against a stalled response port
    for (int k = 0; k < 6; k++)
      send(1'b1, 1'b0, 1'b1, 32'h100 * k, {$urandom, $urandom, $urandom, $urandom});
    drain();
    bus.rsp_ready_i = 1'b0;
    base = n_acc;
    set_req(1'b0, 1'b1, 1'b0, 32'h0, '0);
    bus.req_valid_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      a0 = n_acc;
      step();
      if (n_acc != a0) set_req(1'b0, 1'b1, 1'b0, 32'h100 * (n_acc - base), '0);
    end
    check("burst_accepted", n_acc - base, 5);
    check("burst_full_ready", bus.req_ready_o, 1'b0);
    check("burst_head_valid", bus.rsp_valid_o, 1'b1);
    snap = bus.rsp_data_o;
    base = n_rsp;
    bus.rsp_ready_i = 1'b1;
    n = 0;
    while (bus.req_valid_i && n < 50) begin
      a0 = n_acc;
      step();
      if (n_acc != a0) bus.req_valid_i = 1'b0;
      n++;
    end
    check("burst_sixth_accepted", bus.req_valid_i, 1'b0);
    drain();
    check("burst_rsp_count", n_rsp - base, 6);
    check("burst_first_data", snap, mem_m[0]);

    // Illegal request then a legal read
    send(1'b0, 1'b1, 1'b1, 32'h80, '0);
    check("illegal_err", err, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("illegal_no_rsp", bus.rsp_valid_o, 1'b0);
      step();
    end
    send(1'b0, 1'b1, 1'b0, 32'h40, '0);
    drain();
    check("illegal_err_sticky", err, 1'b1);

    // Randomized traffic with aliased addresses and random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      int   r;
      int   idx;
      logic w;
      r     = $urandom_range(0, 19);
      idx   = $urandom_range(0, 7);
      raddr = ($urandom & 32'hFFFF_C00F) | (32'(idx) << 4);
      if (r == 0) begin
        w = 1'($urandom_range(0, 1));
        send(1'($urandom_range(0, 1)), w, w, raddr, '0);
      end else begin
        w = (r < 9) || !mem_m.exists(idx);
        send(1'($urandom_range(0, 1)), !w, w, raddr, {$urandom, $urandom, $urandom, $urandom});
      end
      repeat ($urandom_range(0, 2)) step();
    end
    drain();
    rand_rdy = 0;
    bus.rsp_ready_i = 1'b1;
`ifdef SEGRE_MEM_STATS_EN
    check("stat_rd_cnt", rd_cnt, rd_done);
    check("stat_wr_cnt", wr_cnt, wr_done);
`endif

    // Asynchronous reset while one request is in service and two are queued
    send(1'b0, 1'b1, 1'b0, 32'h40, '0);
    send(1'b0, 1'b1, 1'b0, 32'h100, '0);
    send(1'b0, 1'b1, 1'b0, 32'h200, '0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    exp_err  = 1'b0;
    hold_vld = 0;
    rd_done  = 0;
    wr_done  = 0;
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      check("post_rst_no_rsp", bus.rsp_valid_o, 1'b0);
      step();
    end

`ifdef SEGRE_MEM_STATS_EN
    for (int k = 0; k < 3; k++)
      send(1'b1, 1'b0, 1'b1, 32'h300 + 32'h10 * k, {4{$urandom}});
    send(1'b1, 1'b1, 1'b1, 32'h300, '0);
    for (int k = 0; k < 5; k++)
      send(1'b0, 1'b1, 1'b0, 32'h300 + 32'h10 * (k % 3), '0);
    drain();
    check("stat_wr_3", wr_cnt, 32'd3);
    check("stat_rd_5", rd_cnt, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
